// File: rtl/mas_ctrl_pkg.sv
// Shared definitions for the MicroarchiSC load/run controller.
package mas_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/run_budget_counter.sv
// Clearable up-counter with a registered flag that is high while count == LIMIT-1.
module run_budget_counter #(
  parameter int unsigned W     = 32,
  parameter int unsigned LIMIT = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_nxt;

  // Next count: clear wins over enable.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = count + W'(1);
    end
  end

  // Count register; hit tracks count == LIMIT-1 so the caller can act on the final cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      hit   <= (LIMIT == 32'd1);
    end else begin
      count <= count_nxt;
      hit   <= (count_nxt == W'(LIMIT - 32'd1));
    end
  end

endmodule

// File: rtl/prog_load_sequencer.sv
// Loads a program into MicroarchiSC over a valid/ready stream, then releases and times the core.
module prog_load_sequencer
  import mas_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned RUN_CYCLES = 512,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic                       in_last,
  output logic                       lp_we,
  output logic [31:0]                lp_addr,
  output logic [31:0]                lp_data,
  output logic                       core_rst,
  output logic [CNT_W-1:0]           run_cnt,
  output logic [$clog2(MAX_WORDS):0] word_cnt,
  output logic                       done,
  output logic                       err_ovf
);

  localparam int unsigned WC_W  = $clog2(MAX_WORDS) + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC) + 1;

  state_t state, state_nxt;
  logic hs_c, accept_c, ovf_c, begin_c;
  logic settle_hit, run_hit;
  logic [SET_W-1:0] unused_settle_cnt;

  // Settle window timer: held clear outside SETTLE.
  run_budget_counter #(.W(SET_W), .LIMIT(SETTLE_CYC)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != S_SETTLE),
    .en   (state == S_SETTLE),
    .count(unused_settle_cnt),
    .hit  (settle_hit)
  );

  // Run budget timer: cleared when a session begins, so run_cnt survives into DONE.
  run_budget_counter #(.W(CNT_W), .LIMIT(RUN_CYCLES)) u_run (
    .clk  (clk),
    .rst  (rst),
    .clr  (begin_c),
    .en   (state == S_RUN),
    .count(run_cnt),
    .hit  (run_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle strobes; an overflowing word is dropped rather than written.
  always_comb begin
    state_nxt = state;
    hs_c      = 1'b0;
    accept_c  = 1'b0;
    ovf_c     = 1'b0;
    begin_c   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          begin_c   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        hs_c = in_valid && in_ready;
        if (hs_c) begin
          if (word_cnt == WC_W'(MAX_WORDS)) begin
            ovf_c     = 1'b1;
            state_nxt = S_DONE;
          end else begin
            accept_c = 1'b1;
            if (in_last) begin
              state_nxt = S_SETTLE;
            end
          end
        end
      end
      S_SETTLE: begin
        if (settle_hit) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (run_hit) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state, plus the write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      lp_we    <= 1'b0;
      lp_addr  <= '0;
      lp_data  <= '0;
      word_cnt <= '0;
      err_ovf  <= 1'b0;
    end else begin
      in_ready <= (state_nxt == S_LOAD);
      core_rst <= (state_nxt != S_RUN);
      done     <= (state_nxt == S_DONE);
      lp_we    <= accept_c;
      if (accept_c) begin
        lp_addr  <= 32'(word_cnt) * 32'(WORD_BYTES);
        lp_data  <= in_data;
        word_cnt <= word_cnt + WC_W'(1);
      end
      if (begin_c) begin
        word_cnt <= '0;
        err_ovf  <= 1'b0;
      end else if (ovf_c) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Directed bench for prog_load_sequencer with a small program memory (8 words).
module tb_prog_load_sequencer;

  localparam int unsigned MW = 8;
  localparam int unsigned SC = 2;
  localparam int unsigned RC = 512;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          lp_we;
  logic [31:0]   lp_addr;
  logic [31:0]   lp_data;
  logic          core_rst;
  logic [CW-1:0] run_cnt;
  logic [3:0]    word_cnt;
  logic          done;
  logic          err_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  bit          saw_run;

  logic [31:0] prog4 [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};

  prog_load_sequencer #(
    .MAX_WORDS (MW),
    .SETTLE_CYC(SC),
    .RUN_CYCLES(RC),
    .CNT_W     (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_last (in_last),
    .lp_we   (lp_we),
    .lp_addr (lp_addr),
    .lp_data (lp_data),
    .core_rst(core_rst),
    .run_cnt (run_cnt),
    .word_cnt(word_cnt),
    .done    (done),
    .err_ovf (err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and run monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (lp_we) begin
      wa_q.push_back(lp_addr);
      wd_q.push_back(lp_data);
      wc_q.push_back(cyc);
    end
    if (!core_rst) saw_run = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    saw_run = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word after `gap` idle cycles and hold it until accepted.
  task automatic send_word(input logic [31:0] d, input bit last, input int gap, output bit ok);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 700) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got %b expected 1 (timeout)", tag, done);
    end
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (core_rst && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_core_rst_fall: got %b expected 0 (timeout)", tag, core_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) tick();
    checks++;
    if ({in_ready, lp_we, core_rst, done, err_ovf} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00100", {in_ready, lp_we, core_rst, done, err_ovf});
    end
    checks++;
    if ({lp_addr, lp_data, run_cnt, word_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got addr %0h data %0h run %0d words %0d expected all 0",
               lp_addr, lp_data, run_cnt, word_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    bit ok;
    clear_mon();
    do_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(prog4[i], i == 3, 0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_handshake: word %0d got no accept expected accept", i);
      end
    end
    wait_run("basic");
    checks++;
    if (wa_q.size() != 4) begin
      errors++;
      $display("FAIL basic_write_count: got %0d expected 4", wa_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== prog4[i]) begin
        errors++;
        $display("FAIL basic_write: idx %0d got %0h/%0h expected %0h/%0h",
                 i, wa_q[i], wd_q[i], 32'(i * 4), prog4[i]);
      end
    end
    checks++;
    if (word_cnt !== 4'd4) begin
      errors++;
      $display("FAIL basic_word_cnt: got %0d expected 4", word_cnt);
    end
    if (wc_q.size() == 4) begin
      checks++;
      if (cyc - wc_q[3] != 2) begin
        errors++;
        $display("FAIL basic_settle: got %0d expected 2 cycles from last write to core_rst fall",
                 cyc - wc_q[3]);
      end
    end
  endtask

  task automatic test_run_budget();
    int n = 1;
    while (n < 700) begin
      tick();
      if (core_rst !== 1'b0) break;
      n++;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL run_low_cycles: got %0d expected 512", n);
    end
    checks++;
    if ({core_rst, done} !== 2'b11 || run_cnt !== 32'd512) begin
      errors++;
      $display("FAIL run_end: got core_rst %b done %b run_cnt %0d expected 1 1 512",
               core_rst, done, run_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_mon();
    do_start();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hA000_0000 + 32'(i), i == 2, 1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_handshake: word %0d got no accept expected accept", i);
      end
    end
    wait_done("bp");
    checks++;
    if (wa_q.size() != 3 || word_cnt !== 4'd3) begin
      errors++;
      $display("FAIL bp_write_count: got %0d writes word_cnt %0d expected 3 3", wa_q.size(), word_cnt);
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL bp_write: idx %0d got %0h/%0h expected %0h/%0h",
                 i, wa_q[i], wd_q[i], 32'(i * 4), 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_mon();
    do_start();
    for (int i = 0; i < 9; i++) begin
      send_word(32'hB000_0000 + 32'(i), 1'b0, 0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ovf_handshake: word %0d got no accept expected accept", i);
      end
    end
    repeat (5) tick();
    checks++;
    if ({err_ovf, done, core_rst, in_ready} !== 4'b1110) begin
      errors++;
      $display("FAIL ovf_flags: got %b expected 1110 (err_ovf done core_rst in_ready)",
               {err_ovf, done, core_rst, in_ready});
    end
    checks++;
    if (saw_run) begin
      errors++;
      $display("FAIL ovf_core_ran: got core_rst low expected always high");
    end
    checks++;
    if (wa_q.size() != 8 || word_cnt !== 4'd8) begin
      errors++;
      $display("FAIL ovf_write_count: got %0d writes word_cnt %0d expected 8 8", wa_q.size(), word_cnt);
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL ovf_addr: idx %0d got %0h expected %0h", i, wa_q[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_restart_from_done();
    bit ok;
    int r0;
    clear_mon();
    do_start();
    checks++;
    if ({err_ovf, done, in_ready} !== 3'b001 || word_cnt !== 4'd0 || run_cnt !== 32'd0) begin
      errors++;
      $display("FAIL restart_clear: got err_ovf %b done %b in_ready %b words %0d run %0d expected 0 0 1 0 0",
               err_ovf, done, in_ready, word_cnt, run_cnt);
    end
    send_word(32'hC0DE_0000, 1'b0, 0, ok);
    send_word(32'hC0DE_0001, 1'b1, 0, ok);
    wait_run("restart");
    repeat (10) tick();
    r0 = int'(run_cnt);
    start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    repeat (3) tick();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({core_rst, in_ready, done} !== 3'b000 || int'(run_cnt) != r0 + 3) begin
      errors++;
      $display("FAIL restart_start_in_run: got core_rst %b in_ready %b done %b run %0d expected 0 0 0 %0d",
               core_rst, in_ready, done, run_cnt, r0 + 3);
    end
    wait_done("restart");
    checks++;
    if (wa_q.size() != 2 || run_cnt !== 32'd512) begin
      errors++;
      $display("FAIL restart_writes: got %0d writes run %0d expected 2 512", wa_q.size(), run_cnt);
    end
    for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== 32'hC0DE_0000 + 32'(i)) begin
        errors++;
        $display("FAIL restart_write: idx %0d got %0h/%0h expected %0h/%0h",
                 i, wa_q[i], wd_q[i], 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_last_at_capacity();
    bit ok;
    clear_mon();
    do_start();
    for (int i = 0; i < 8; i++) send_word(32'hD000_0000 + 32'(i), i == 7, 0, ok);
    wait_run("cap");
    checks++;
    if (wa_q.size() != 8 || err_ovf !== 1'b0 || word_cnt !== 4'd8) begin
      errors++;
      $display("FAIL cap_load: got %0d writes err_ovf %b words %0d expected 8 0 8",
               wa_q.size(), err_ovf, word_cnt);
    end
    if (wa_q.size() == 8) begin
      checks++;
      if (wa_q[7] !== 32'd28 || wd_q[7] !== 32'hD000_0007) begin
        errors++;
        $display("FAIL cap_last_write: got %0h/%0h expected 1c/d0000007", wa_q[7], wd_q[7]);
      end
    end
    wait_done("cap");
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int n = 0;
    clear_mon();
    do_start();
    send_word(32'h1111_1111, 1'b0, 0, ok);
    send_word(32'h2222_2222, 1'b1, 0, ok);
    while (run_cnt != 32'd100 && n < 700) begin
      tick();
      n++;
    end
    checks++;
    if (run_cnt !== 32'd100 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_reach: got run %0d core_rst %b expected 100 0", run_cnt, core_rst);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({core_rst, done, in_ready, lp_we} !== 4'b1000 || run_cnt !== 32'd0 || word_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async: got core_rst %b done %b in_ready %b lp_we %b run %0d words %0d expected 1 0 0 0 0 0",
               core_rst, done, in_ready, lp_we, run_cnt, word_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({core_rst, done, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_idle: got core_rst %b done %b in_ready %b expected 1 0 0", core_rst, done, in_ready);
    end
    clear_mon();
    do_start();
    send_word(32'h3333_3333, 1'b0, 0, ok);
    send_word(32'h4444_4444, 1'b1, 0, ok);
    wait_run("rstmid_reload");
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL rstmid_reload_count: got %0d expected 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'd0 || wa_q[1] !== 32'd4 || wd_q[0] !== 32'h3333_3333 || wd_q[1] !== 32'h4444_4444) begin
        errors++;
        $display("FAIL rstmid_reload: got %0h/%0h %0h/%0h expected 0/33333333 4/44444444",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_run_budget();
    test_backpressure();
    test_overflow();
    test_restart_from_done();
    test_last_at_capacity();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
